axil_spi_regs: RTL and testbench
================================

Name: axil_spi_regs

Overview:
- AXI4-Lite slave (responder) register bank for the AXIL_SPI peripheral. The S00_AXI master drives it.
- Decodes 32-bit register accesses and drives control and data fields into the SPI shift engine. Returns SPI status and receive data to the bus.
- One outstanding write and one outstanding read at a time; the two channels operate independently.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus data width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width. Covers 8 word slots.
- RESP_SLVERR_UNMAPPED, 1, if 1, accesses to 0x18–0x1C return SLVERR (2'b10). If 0, they return OKAY.

Ports:
- s00_axi_aclk  in  1  single clock.
- s00_axi_aresetn  in  1  reset; asynchronous assert, active-low.
- s00_axi_awaddr  in  5  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in/out  1  write-address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in/out  1  write-data handshake.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid / s00_axi_bready  out/in  1  write-response handshake.
- s00_axi_araddr  in  5  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in/out  1  read-address handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid / s00_axi_rready  out/in  1  read-data handshake.
- spi_ctrl  out  32  value of the CTRL register.
- spi_tx_data  out  32  value of the TXDATA register.
- spi_tx_start  out  1  one-cycle pulse on a TXDATA write.
- spi_clkdiv  out  32  value of the CLKDIV register.
- spi_busy  in  1  shift engine is busy.
- spi_rx_data  in  32  received word.
- spi_rx_valid  in  1  one-cycle pulse when a received word is ready.

Behaviour:
- Register map (word-aligned; awaddr[1:0] and araddr[1:0] are ignored):
  - 0x00 CTRL, RW.
  - 0x04 TXDATA, RW.
  - 0x08 CLKDIV, RW.
  - 0x0C SCRATCH, RW.
  - 0x10 STATUS, RO: bit0 = busy, bit1 = rx_pending, other bits 0.
  - 0x14 RXDATA, RO. A read clears rx_pending.
  - 0x18–0x1C unmapped: read data 0, writes are ignored.
- Reset: all RW registers 0, rx_data latch 0, rx_pending 0. All VALID and READY outputs 0 while reset is asserted. bresp = rresp = 0, rdata = 0, spi_tx_start = 0.
- Write channel:
  - AW and W are captured independently into single-entry holding registers, aw_full and w_full.
  - awready = !aw_full && !bvalid; wready = !w_full && !bvalid.
  - Commit cycle: when aw_full && w_full && !bvalid, the target register is updated with a per-byte merge under wstrb, bvalid is set, and both holding registers are cleared.
  - Latency: if AW and W handshake on the same edge N, the register updates and bvalid rises at edge N+1.
  - bvalid holds until bready; it clears on the edge where bvalid && bready. The next AW/W can be accepted in the cycle after that.
  - AW arriving before W, or W before AW, at any skew: the earlier beat is held and awready or wready (whichever applies) stays low until commit.
  - Writes to RO or unmapped addresses change no state. bresp is OKAY for RO; for unmapped it is SLVERR if RESP_SLVERR_UNMAPPED, else OKAY.
  - A write to TXDATA with any strobe set produces spi_tx_start = 1 for exactly the commit cycle + 1. This happens regardless of spi_busy; the engine owns overrun policy. wstrb = 0 gives no pulse and no change, with bresp OKAY.
- Read channel:
  - arready = !rvalid.
  - On an AR handshake at edge N, rdata and rresp are registered from the register values as they stand before edge N, and rvalid rises at N+1.
  - rdata and rresp are held stable until rvalid && rready.
  - A simultaneous write commit and read of the same register returns the old value.
- rx path:
  - spi_rx_valid loads the rx_data latch and sets rx_pending.
  - A completed RXDATA read clears rx_pending on the AR handshake edge.
  - If spi_rx_valid coincides with that clear, set wins: the new data is loaded and rx_pending stays 1.
- Reset asserted mid-transaction aborts it: pending beats are dropped and no response is issued after release.
- Backpressure: bready or rready held low for any duration stalls only its own channel.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C, then read them back -> reads return 0x1, 0x2, 0x3, 0x4 with OKAY, and spi_tx_start pulses exactly once.
- AW at cycle 0, W at cycle 5 (and the reverse order), addr 0x0C, data 0xA5A5A5A5 -> single bvalid at W+1, readback 0xA5A5A5A5.
- Write 0xDEADBEEF to 0x08 with wstrb = 4'b0101 over an initial value of 0x11223344 -> readback 0x11AD33EF.
- Pulse spi_rx_valid with 0xCAFE0001 -> STATUS reads 0x2 and RXDATA reads 0xCAFE0001, after which STATUS reads 0x0. Then pulse spi_rx_valid on the same edge as the RXDATA AR handshake -> STATUS reads 0x2.
- Write to 0x18 with RESP_SLVERR_UNMAPPED = 1 -> bresp 2'b10 and no register changes. Read 0x18 -> rdata 0, rresp 2'b10. Write 0xFFFF to 0x10 -> bresp OKAY and STATUS is unchanged.
- Hold bready low for 10 cycles after a write -> awready and wready stay 0 and bvalid stays 1. Assert aresetn low mid-hold -> bvalid is 0 immediately and all registers read 0 after reset.

Source files
------------

// File: rtl/axil_spi_regs.sv
// AXI4-Lite register bank for the AXIL_SPI peripheral: CTRL/TXDATA/CLKDIV/SCRATCH
// control registers, STATUS and RXDATA readback, and a TX start pulse to the shift engine.
`timescale 1ns/1ps
module axil_spi_regs #(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_S_AXI_ADDR_WIDTH   = 5,
  parameter bit RESP_SLVERR_UNMAPPED = 1'b1
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [31:0]                     spi_ctrl,
  output logic [31:0]                     spi_tx_data,
  output logic                            spi_tx_start,
  output logic [31:0]                     spi_clkdiv,
  input  logic                            spi_busy,
  input  logic [31:0]                     spi_rx_data,
  input  logic                            spi_rx_valid
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_UNMAP  = RESP_SLVERR_UNMAPPED ? RESP_SLVERR : RESP_OKAY;

  logic        aw_full_q, aw_full_d;
  logic [2:0]  aw_idx_q, aw_idx_d;
  logic        w_full_q, w_full_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] txdata_q, txdata_d;
  logic [31:0] clkdiv_q, clkdiv_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic        rx_pending_q, rx_pending_d;
  logic        tx_start_q, tx_start_d;

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [2:0]  ar_idx;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;
  logic [31:0] merged;

  // Address LSBs and protection bits carry no meaning for this block.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Readies are forced low while reset is held, not just after the first edge.
  assign s00_axi_awready = s00_axi_aresetn && !aw_full_q && !bvalid_q;
  assign s00_axi_wready  = s00_axi_aresetn && !w_full_q && !bvalid_q;
  assign s00_axi_arready = s00_axi_aresetn && !rvalid_q;

  assign aw_hs  = s00_axi_awvalid && s00_axi_awready;
  assign w_hs   = s00_axi_wvalid && s00_axi_wready;
  assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
  assign commit = aw_full_q && w_full_q && !bvalid_q;
  assign ar_idx = s00_axi_araddr[4:2];

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    rd_word = 32'h0;
    rd_resp = RESP_OKAY;
    case (ar_idx)
      3'd0:    rd_word = ctrl_q;
      3'd1:    rd_word = txdata_q;
      3'd2:    rd_word = clkdiv_q;
      3'd3:    rd_word = scratch_q;
      3'd4:    rd_word = {30'h0, rx_pending_q, spi_busy};
      3'd5:    rd_word = rx_data_q;
      default: rd_resp = RESP_UNMAP;
    endcase
  end

  assign merged = byte_merge(
      (aw_idx_q == 3'd0) ? ctrl_q :
      (aw_idx_q == 3'd1) ? txdata_q :
      (aw_idx_q == 3'd2) ? clkdiv_q : scratch_q,
      w_data_q, w_strb_q);

  always_comb begin
    aw_full_d    = aw_full_q;
    aw_idx_d     = aw_idx_q;
    w_full_d     = w_full_q;
    w_data_d     = w_data_q;
    w_strb_d     = w_strb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    ctrl_d       = ctrl_q;
    txdata_d     = txdata_q;
    clkdiv_d     = clkdiv_q;
    scratch_d    = scratch_q;
    rx_data_d    = rx_data_q;
    rx_pending_d = rx_pending_q;
    tx_start_d   = 1'b0;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s00_axi_awaddr[4:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s00_axi_wdata[31:0];
      w_strb_d = s00_axi_wstrb[3:0];
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      case (aw_idx_q)
        3'd0: ctrl_d    = merged;
        3'd1: begin
          txdata_d   = merged;
          tx_start_d = |w_strb_q;
        end
        3'd2: clkdiv_d  = merged;
        3'd3: scratch_d = merged;
        3'd6, 3'd7: bresp_d = RESP_UNMAP;
        default: ;
      endcase
    end else if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
    end

    // Read data is snapshotted from pre-edge state, so a same-cycle commit is not visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rd_resp;
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end

    // A new received word outranks the clear from an RXDATA read on the same edge.
    if (spi_rx_valid) begin
      rx_data_d    = spi_rx_data;
      rx_pending_d = 1'b1;
    end else if (ar_hs && ar_idx == 3'd5) begin
      rx_pending_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_full_q    <= 1'b0;
      aw_idx_q     <= 3'd0;
      w_full_q     <= 1'b0;
      w_data_q     <= 32'h0;
      w_strb_q     <= 4'h0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'h0;
      rresp_q      <= RESP_OKAY;
      ctrl_q       <= 32'h0;
      txdata_q     <= 32'h0;
      clkdiv_q     <= 32'h0;
      scratch_q    <= 32'h0;
      rx_data_q    <= 32'h0;
      rx_pending_q <= 1'b0;
      tx_start_q   <= 1'b0;
    end else begin
      aw_full_q    <= aw_full_d;
      aw_idx_q     <= aw_idx_d;
      w_full_q     <= w_full_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      ctrl_q       <= ctrl_d;
      txdata_q     <= txdata_d;
      clkdiv_q     <= clkdiv_d;
      scratch_q    <= scratch_d;
      rx_data_q    <= rx_data_d;
      rx_pending_q <= rx_pending_d;
      tx_start_q   <= tx_start_d;
    end
  end

  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_bresp  = bresp_q;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rresp  = rresp_q;
  assign s00_axi_rdata  = {{(C_S_AXI_DATA_WIDTH-32){1'b0}}, rdata_q};
  assign spi_ctrl       = ctrl_q;
  assign spi_tx_data    = txdata_q;
  assign spi_clkdiv     = clkdiv_q;
  assign spi_tx_start   = tx_start_q;

endmodule

// File: tb/tb_axil_spi_regs.sv
// Directed bench for axil_spi_regs: register access, skewed beats, strobes,
// rx pending handling, unmapped/RO writes, backpressure and reset abort.
`timescale 1ns/1ps
module tb_axil_spi_regs;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] spi_ctrl, spi_tx_data, spi_clkdiv;
  logic        spi_tx_start;
  logic        spi_busy = 1'b0;
  logic [31:0] spi_rx_data = '0;
  logic        spi_rx_valid = 1'b0;

  int checks = 0;
  int failures = 0;
  int tx_cnt = 0;

  always #5 clk = ~clk;

  axil_spi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .RESP_SLVERR_UNMAPPED(1'b1)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr),
    .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata(wdata),
    .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid),
    .s00_axi_wready(wready),
    .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready),
    .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata(rdata),
    .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready),
    .spi_ctrl(spi_ctrl),
    .spi_tx_data(spi_tx_data),
    .spi_tx_start(spi_tx_start),
    .spi_clkdiv(spi_clkdiv),
    .spi_busy(spi_busy),
    .spi_rx_data(spi_rx_data),
    .spi_rx_valid(spi_rx_valid)
  );

  always @(posedge clk) if (spi_tx_start) tx_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-20s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_done, w_done, aw_hs, w_hs;
    aw_done = 1'b0;
    w_done  = 1'b0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid = 1'b0;  w_done = 1'b1;  end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) check("aw_w_accept_timeout", {30'h0, aw_done, w_done}, 32'h3);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    for (int i = 0; i < 50 && !bvalid; i++) tick();
    if (!bvalid) check("bvalid_timeout", {31'h0, bvalid}, 32'h1);
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    send_beats(a, d, s);
    wait_b(resp);
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic hs, done;
    done = 1'b0;
    araddr = a;
    arvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      hs = arvalid && arready;
      tick();
      if (hs) done = 1'b1;
    end
    arvalid = 1'b0;
    if (!done) check("ar_accept_timeout", {31'h0, done}, 32'h1);
    for (int i = 0; i < 50 && !rvalid; i++) tick();
    if (!rvalid) check("rvalid_timeout", {31'h0, rvalid}, 32'h1);
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int tx_before;

    // Reset values while aresetn is held low
    repeat (3) tick();
    check("rst_awready", {31'h0, awready}, 32'h0);
    check("rst_wready", {31'h0, wready}, 32'h0);
    check("rst_arready", {31'h0, arready}, 32'h0);
    check("rst_bvalid", {31'h0, bvalid}, 32'h0);
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_tx_start", {31'h0, spi_tx_start}, 32'h0);
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    check("awready_after_rst", {31'h0, awready}, 32'h1);

    // Basic write/readback of the four RW registers
    do_write(5'h00, 32'h1, 4'hF, resp); check("wr_ctrl_bresp", {30'h0, resp}, 32'h0);
    do_write(5'h04, 32'h2, 4'hF, resp); check("wr_tx_bresp", {30'h0, resp}, 32'h0);
    do_write(5'h08, 32'h3, 4'hF, resp); check("wr_clkdiv_bresp", {30'h0, resp}, 32'h0);
    do_write(5'h0C, 32'h4, 4'hF, resp); check("wr_scratch_bresp", {30'h0, resp}, 32'h0);
    do_read(5'h00, data, resp); check("rd_ctrl", data, 32'h1); check("rd_ctrl_rresp", {30'h0, resp}, 32'h0);
    do_read(5'h04, data, resp); check("rd_tx", data, 32'h2);   check("rd_tx_rresp", {30'h0, resp}, 32'h0);
    do_read(5'h08, data, resp); check("rd_clkdiv", data, 32'h3); check("rd_clkdiv_rresp", {30'h0, resp}, 32'h0);
    do_read(5'h0C, data, resp); check("rd_scratch", data, 32'h4); check("rd_scr_rresp", {30'h0, resp}, 32'h0);
    check("spi_ctrl_out", spi_ctrl, 32'h1);
    check("spi_tx_data_out", spi_tx_data, 32'h2);
    check("spi_clkdiv_out", spi_clkdiv, 32'h3);
    check("tx_start_once", tx_cnt, 32'd1);

    // AW leads W by five cycles
    awaddr = 5'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("aw_lead_awready", {31'h0, awready}, 32'h0);
      check("aw_lead_bvalid", {31'h0, bvalid}, 32'h0);
    end
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("aw_lead_b_not_early", {31'h0, bvalid}, 32'h0);
    tick();
    check("aw_lead_b_at_w1", {31'h0, bvalid}, 32'h1);
    check("aw_lead_bresp", {30'h0, bresp}, 32'h0);
    bready = 1'b1; tick(); bready = 1'b0;
    check("aw_lead_b_cleared", {31'h0, bvalid}, 32'h0);
    do_read(5'h0C, data, resp); check("aw_lead_readback", data, 32'hA5A5A5A5);

    // W leads AW by five cycles
    wdata = 32'h3C3C3C3C; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("w_lead_wready", {31'h0, wready}, 32'h0);
      check("w_lead_bvalid", {31'h0, bvalid}, 32'h0);
    end
    awaddr = 5'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("w_lead_b_not_early", {31'h0, bvalid}, 32'h0);
    tick();
    check("w_lead_b_at_aw1", {31'h0, bvalid}, 32'h1);
    bready = 1'b1; tick(); bready = 1'b0;
    do_read(5'h0C, data, resp); check("w_lead_readback", data, 32'h3C3C3C3C);

    // Byte strobes
    do_write(5'h08, 32'h11223344, 4'hF, resp);
    do_write(5'h08, 32'hDEADBEEF, 4'b0101, resp);
    do_read(5'h08, data, resp); check("strobe_merge", data, 32'h11AD33EF);
    tx_before = tx_cnt;
    do_write(5'h04, 32'hFFFFFFFF, 4'h0, resp);
    check("tx_nostrb_bresp", {30'h0, resp}, 32'h0);
    check("tx_nostrb_no_pulse", tx_cnt, tx_before);
    do_read(5'h04, data, resp); check("tx_nostrb_unchanged", data, 32'h2);

    // Receive path
    @(negedge clk);
    spi_rx_data = 32'hCAFE0001; spi_rx_valid = 1'b1;
    @(negedge clk);
    spi_rx_valid = 1'b0;
    #1;
    do_read(5'h10, data, resp); check("status_pending", data, 32'h2);
    do_read(5'h14, data, resp); check("rxdata", data, 32'hCAFE0001);
    do_read(5'h10, data, resp); check("status_cleared", data, 32'h0);
    // rx word arrives on the RXDATA AR handshake edge
    araddr = 5'h14; arvalid = 1'b1;
    spi_rx_data = 32'h12345678; spi_rx_valid = 1'b1;
    check("coinc_arready", {31'h0, arready}, 32'h1);
    tick();
    arvalid = 1'b0; spi_rx_valid = 1'b0;
    check("coinc_rvalid", {31'h0, rvalid}, 32'h1);
    check("coinc_rdata_old", rdata, 32'hCAFE0001);
    rready = 1'b1; tick(); rready = 1'b0;
    do_read(5'h10, data, resp); check("coinc_status_set", data, 32'h2);
    spi_busy = 1'b1;
    do_read(5'h14, data, resp); check("coinc_rxdata_new", data, 32'h12345678);
    do_read(5'h10, data, resp); check("status_busy_only", data, 32'h1);
    spi_busy = 1'b0;

    // Unmapped and read-only targets
    do_write(5'h18, 32'hFFFFFFFF, 4'hF, resp); check("unmap_bresp", {30'h0, resp}, 32'h2);
    do_read(5'h00, data, resp); check("unmap_ctrl_kept", data, 32'h1);
    do_read(5'h0C, data, resp); check("unmap_scr_kept", data, 32'h3C3C3C3C);
    do_read(5'h18, data, resp); check("unmap_rdata", data, 32'h0);
    check("unmap_rresp", {30'h0, resp}, 32'h2);
    do_write(5'h10, 32'h0000FFFF, 4'hF, resp); check("ro_bresp", {30'h0, resp}, 32'h0);
    do_read(5'h10, data, resp); check("ro_status_kept", data, 32'h0);

    // Write response backpressure, then reset in the middle of it
    send_beats(5'h00, 32'h77, 4'hF);
    for (int i = 0; i < 50 && !bvalid; i++) tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_bvalid", {31'h0, bvalid}, 32'h1);
      check("bp_awready", {31'h0, awready}, 32'h0);
      check("bp_wready", {31'h0, wready}, 32'h0);
      tick();
    end
    aresetn = 1'b0;
    #1;
    check("abort_bvalid", {31'h0, bvalid}, 32'h0);
    check("abort_awready", {31'h0, awready}, 32'h0);
    repeat (2) tick();
    @(negedge clk);
    aresetn = 1'b1;
    repeat (3) tick();
    check("abort_no_b_after", {31'h0, bvalid}, 32'h0);
    do_read(5'h00, data, resp); check("post_rst_ctrl", data, 32'h0);
    do_read(5'h04, data, resp); check("post_rst_tx", data, 32'h0);
    do_read(5'h08, data, resp); check("post_rst_clkdiv", data, 32'h0);
    do_read(5'h0C, data, resp); check("post_rst_scratch", data, 32'h0);
    do_read(5'h10, data, resp); check("post_rst_status", data, 32'h0);
    do_read(5'h14, data, resp); check("post_rst_rxdata", data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
